// File: rtl/fp16_to_fixed.sv
// Iterative binary16 -> signed fixed-point converter: unpack and classify on accept,
// align the mantissa one bit per cycle, then saturate/negate into a registered result.
module fp16_to_fixed #(
    parameter int OUT_W  = 32,
    parameter int FRAC_W = 8
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    input  logic [15:0]             IN_DATA,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic signed [OUT_W-1:0] OUT_DATA,
    output logic [4:0]              OUT_FLAGS
);

    localparam int MAG_W = 16 + FRAC_W;
    localparam int CMP_W = ((MAG_W > OUT_W) ? MAG_W : OUT_W) + 1;
    localparam logic signed [7:0] K_OFS = 8'(FRAC_W - 25);
    localparam logic signed [OUT_W-1:0] MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] MIN_NEG = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, SHIFT, FIX, DONE} state_t;

    state_t             state;
    logic [MAG_W-1:0]   mag;
    logic [5:0]         cnt;
    logic               sign, left, inexact;
    logic               cls_zero, cls_inf, cls_nan;

    logic [4:0]         exp_in, e_eff;
    logic [9:0]         man_in;
    logic signed [7:0]  k;
    logic [7:0]         k_abs;
    logic [5:0]         n_in;
    logic               is_special;
    logic [10:0]        m_full;

    logic [OUT_W:0]           sat;
    logic signed [OUT_W-1:0]  fix_data;
    logic [4:0]               fix_flags;

    // Clamp a magnitude/sign pair into the signed output range; MSB of the result is OVF.
    function automatic logic [OUT_W:0] saturate(input logic s, input logic [MAG_W-1:0] m);
        logic [CMP_W-1:0] mw;
        logic [CMP_W-1:0] lim;
        logic [OUT_W-1:0] mo;
        mw = CMP_W'(m);
        lim = '0;
        lim[OUT_W-1] = 1'b1;
        mo = OUT_W'(m);
        if (!s && mw >= lim) return {1'b1, MAX_POS};
        if (s && mw > lim) return {1'b1, MIN_NEG};
        return {1'b0, s ? (~mo + 1'b1) : mo};
    endfunction

    assign IN_READY = (state == IDLE) && !RESET;

    always_comb begin
        exp_in     = IN_DATA[14:10];
        man_in     = IN_DATA[9:0];
        is_special = (exp_in == 5'd31) || ((exp_in == 5'd0) && (man_in == 10'd0));
        e_eff      = (exp_in == 5'd0) ? 5'd1 : exp_in;
        m_full     = {(exp_in != 5'd0), man_in};
        k          = $signed({3'b000, e_eff}) + K_OFS;
        k_abs      = k[7] ? 8'(-k) : 8'(k);
        // Right shifts past 12 cannot change the result: the 11-bit mantissa is already gone.
        if (is_special)
            n_in = 6'd0;
        else if (k[7] && (k_abs > 8'd12))
            n_in = 6'd12;
        else
            n_in = k_abs[5:0];
    end

    always_comb begin
        sat       = saturate(sign, mag);
        fix_data  = sat[OUT_W-1:0];
        fix_flags = {3'b000, sat[OUT_W], inexact};
        if (cls_nan) begin
            fix_data  = '0;
            fix_flags = 5'b01000;
        end else if (cls_inf) begin
            fix_data  = sign ? MIN_NEG : MAX_POS;
            fix_flags = 5'b00110;
        end else if (cls_zero) begin
            fix_data  = '0;
            fix_flags = 5'b10000;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            OUT_VALID <= 1'b0;
            OUT_DATA  <= '0;
            OUT_FLAGS <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (IN_VALID && IN_READY)
                        state <= (n_in == 6'd0) ? FIX : SHIFT;
                end
                SHIFT: begin
                    if (cnt == 6'd1)
                        state <= FIX;
                end
                FIX: begin
                    OUT_DATA  <= fix_data;
                    OUT_FLAGS <= fix_flags;
                    OUT_VALID <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (OUT_READY) begin
                        OUT_VALID <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath: loaded on accept, walked by the FSM; no reset needed.
    always_ff @(posedge CLK) begin
        case (state)
            IDLE: begin
                if (IN_VALID) begin
                    mag      <= MAG_W'(m_full);
                    sign     <= IN_DATA[15];
                    left     <= ~k[7];
                    cnt      <= n_in;
                    inexact  <= 1'b0;
                    cls_zero <= (exp_in == 5'd0) && (man_in == 10'd0);
                    cls_inf  <= (exp_in == 5'd31) && (man_in == 10'd0);
                    cls_nan  <= (exp_in == 5'd31) && (man_in != 10'd0);
                end
            end
            SHIFT: begin
                if (left) begin
                    mag <= {mag[MAG_W-2:0], 1'b0};
                end else begin
                    mag     <= mag >> 1;
                    inexact <= inexact | mag[0];
                end
                cnt <= cnt - 6'd1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fp16_to_fixed.sv
// Bench for fp16_to_fixed: two instances (OUT_W=32 and OUT_W=16, FRAC_W=8) driven in lockstep,
// directed vector table, handshake/reset sequences and random operands against a value model.
module tb_fp16_to_fixed;

    localparam int FRAC = 8;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;

    logic        in_ready32, out_valid32;
    logic [31:0] out_data32;
    logic [4:0]  out_flags32;
    logic        in_ready16, out_valid16;
    logic [15:0] out_data16;
    logic [4:0]  out_flags16;

    int total = 0;
    int bad = 0;

    fp16_to_fixed #(.OUT_W(32), .FRAC_W(FRAC)) dut32 (
        .CLK(clk), .RESET(reset), .IN_VALID(in_valid), .IN_READY(in_ready32),
        .IN_DATA(in_data), .OUT_VALID(out_valid32), .OUT_READY(out_ready),
        .OUT_DATA(out_data32), .OUT_FLAGS(out_flags32));

    fp16_to_fixed #(.OUT_W(16), .FRAC_W(FRAC)) dut16 (
        .CLK(clk), .RESET(reset), .IN_VALID(in_valid), .IN_READY(in_ready16),
        .IN_DATA(in_data), .OUT_VALID(out_valid16), .OUT_READY(out_ready),
        .OUT_DATA(out_data16), .OUT_FLAGS(out_flags16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] x;
        logic [31:0] d32;
        logic [4:0]  f32;
        logic [15:0] d16;
        logic [4:0]  f16;
        int          n;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Value model: the operand is M * 2^(E-25); scale by 2^FRAC, truncate toward zero, clamp.
    task automatic model(input logic [15:0] x, input int w, output longint d,
                         output logic [4:0] f, output int n);
        logic s;
        int e, m, mm, ee, k;
        longint v, val, maxp, minn;
        logic inx, ovf;
        s = x[15];
        e = int'(x[14:10]);
        m = int'(x[9:0]);
        maxp = (64'sd1 <<< (w - 1)) - 1;
        minn = -(64'sd1 <<< (w - 1));
        n = 0;
        if (e == 31) begin
            if (m != 0) begin d = 0; f = 5'b01000; end
            else begin d = s ? minn : maxp; f = 5'b00110; end
        end else if (e == 0 && m == 0) begin
            d = 0; f = 5'b10000;
        end else begin
            mm = (e == 0) ? m : 1024 + m;
            ee = (e == 0) ? 1 : e;
            k = ee - 25 + FRAC;
            if (k >= 0) begin
                v = longint'(mm) <<< k;
                inx = 1'b0;
                n = k;
            end else begin
                v = longint'(mm) >>> (-k);
                inx = ((v <<< (-k)) != longint'(mm));
                n = (-k > 12) ? 12 : -k;
            end
            val = s ? -v : v;
            ovf = 1'b0;
            if (val > maxp) begin val = maxp; ovf = 1'b1; end
            else if (val < minn) begin val = minn; ovf = 1'b1; end
            d = val;
            f = {3'b000, ovf, inx};
        end
    endtask

    task automatic txn(input logic [15:0] x, input logic [31:0] e32, input logic [4:0] ef32,
                       input logic [15:0] e16, input logic [4:0] ef16, input int n, input int hold);
        int lat;
        bit seen;
        @(negedge clk);
        check("in_ready_idle32", in_ready32, 1);
        check("in_ready_idle16", in_ready16, 1);
        in_data = x;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data = 16'($urandom);
        check("in_ready_busy", in_ready32, 0);
        lat = 1;
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            if (out_valid32 && out_valid16) begin seen = 1; break; end
            @(posedge clk); #1;
            lat++;
        end
        check("out_valid_seen", seen, 1);
        if (!seen) return;
        check("latency", lat, n + 2);
        check("data32", out_data32, e32);
        check("flags32", out_flags32, ef32);
        check("data16", out_data16, e16);
        check("flags16", out_flags16, ef16);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", out_valid32, 1);
            check("hold_data32", out_data32, e32);
            check("hold_flags16", out_flags16, ef16);
            check("hold_in_ready", in_ready32, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("valid_drop32", out_valid32, 0);
        check("valid_drop16", out_valid16, 0);
        check("in_ready_back", in_ready32, 1);
    endtask

    task automatic txn_model(input logic [15:0] x, input int hold);
        longint d32, d16;
        logic [4:0] f32, f16;
        int n, n2;
        model(x, 32, d32, f32, n);
        model(x, 16, d16, f16, n2);
        txn(x, d32[31:0], f32, d16[15:0], f16, n, hold);
    endtask

    vec_t vecs[$];

    initial begin
        int seen_v;
        logic [15:0] x;
        reset = 1'b1;
        in_valid = 1'b0;
        in_data = 16'h0000;
        out_ready = 1'b0;

        vecs.push_back('{16'h3C00, 32'h0000_0100, 5'b00000, 16'h0100, 5'b00000, 2});
        vecs.push_back('{16'hC500, 32'hFFFF_FB00, 5'b00000, 16'hFB00, 5'b00000, 0});
        vecs.push_back('{16'h0001, 32'h0000_0000, 5'b00001, 16'h0000, 5'b00001, 12});
        vecs.push_back('{16'h3E01, 32'h0000_0180, 5'b00001, 16'h0180, 5'b00001, 2});
        vecs.push_back('{16'h7BFF, 32'h00FF_E000, 5'b00000, 16'h7FFF, 5'b00010, 13});
        vecs.push_back('{16'hFBFF, 32'hFF00_2000, 5'b00000, 16'h8000, 5'b00010, 13});
        vecs.push_back('{16'h7C00, 32'h7FFF_FFFF, 5'b00110, 16'h7FFF, 5'b00110, 0});
        vecs.push_back('{16'hFC00, 32'h8000_0000, 5'b00110, 16'h8000, 5'b00110, 0});
        vecs.push_back('{16'h7E00, 32'h0000_0000, 5'b01000, 16'h0000, 5'b01000, 0});
        vecs.push_back('{16'hFE00, 32'h0000_0000, 5'b01000, 16'h0000, 5'b01000, 0});
        vecs.push_back('{16'h8000, 32'h0000_0000, 5'b10000, 16'h0000, 5'b10000, 0});
        vecs.push_back('{16'h0000, 32'h0000_0000, 5'b10000, 16'h0000, 5'b10000, 0});
        vecs.push_back('{16'h5800, 32'h0000_8000, 5'b00000, 16'h7FFF, 5'b00010, 5});
        vecs.push_back('{16'hD800, 32'hFFFF_8000, 5'b00000, 16'h8000, 5'b00000, 5});
        vecs.push_back('{16'h8001, 32'h0000_0000, 5'b00001, 16'h0000, 5'b00001, 12});
        vecs.push_back('{16'h3800, 32'h0000_0080, 5'b00000, 16'h0080, 5'b00000, 3});

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready32", in_ready32, 0);
        check("rst_in_ready16", in_ready16, 0);
        check("rst_out_valid", out_valid32, 0);
        check("rst_out_data32", out_data32, 0);
        check("rst_out_flags32", out_flags32, 0);
        check("rst_out_data16", out_data16, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready32, 1);

        foreach (vecs[i])
            txn(vecs[i].x, vecs[i].d32, vecs[i].f32, vecs[i].d16, vecs[i].f16, vecs[i].n, i % 3);

        // Consumer stalls for five cycles while the result sits in DONE.
        txn(16'hC500, 32'hFFFF_FB00, 5'b00000, 16'hFB00, 5'b00000, 0, 5);

        // Reset asserted while the long right-shift sequence is running.
        @(negedge clk);
        in_data = 16'h0001;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_in_ready", in_ready32, 0);
        check("midrst_out_valid", out_valid32, 0);
        reset = 1'b0;
        #1;
        check("midrst_idle", in_ready32, 1);
        seen_v = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid32 || out_valid16) seen_v++;
        end
        check("midrst_no_output", seen_v, 0);
        txn(16'h3C00, 32'h0000_0100, 5'b00000, 16'h0100, 5'b00000, 2, 0);

        for (int i = 0; i < 150; i++) begin
            x = 16'($urandom);
            if (i % 8 == 0) x[14:10] = 5'd0;
            if (i % 8 == 1) x[14:10] = 5'd31;
            if (i % 8 == 2) x[14:10] = 5'($urandom_range(28, 30));
            txn_model(x, int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
